cla_response_checker: RTL and testbench

Synchronous response checker for the adder timing bench. It is the receiving end of the exhaustive-transition stimulus stream that drives `{a, b, c0}` into a carry-lookahead adder under test. For each applied transition it samples the adder's `{c3, s}` every clock and computes the golden sum. It measures the settle time in cycles, counts wrong or unsettled results, and records the worst-case transition pair, so the max-delay search runs in hardware instead of in a `$time` monitor.

---
 rtl/cla_response_checker.sv | 136 +++++++++++++
 tb/tb_cla_response_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_response_checker.sv
// Receiving end of the CLA adder timing bench: measures per-transition settle time,
// counts failed windows and records the worst-case transition pair in hardware.
module cla_response_checker #(
    parameter int W       = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stim_valid,
    input  logic [2*W:0]     stim,
    input  logic             sweep_end,
    input  logic             dut_c,
    input  logic [W-1:0]     dut_s,
    output logic             result_valid,
    output logic [CNT_W-1:0] settle_cnt,
    output logic             result_err,
    output logic [CNT_W-1:0] max_settle,
    output logic [2*W:0]     max_from,
    output logic [2*W:0]     max_to,
    output logic [15:0]      err_cnt,
    output logic             err_flag,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MEASURE, HOLD, DONE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           next_state;
    logic [2*W:0]     cur;
    logic [2*W:0]     prev;
    logic [W:0]       expected;
    logic [W:0]       stim_sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_bad;
    logic [CNT_W-1:0] sample_idx;
    logic [CNT_W-1:0] settle;
    logic             sample_bad;
    logic             close_win;
    logic             clear_stats;

    assign stim_sum = {1'b0, stim[2*W:W+1]} + {1'b0, stim[W:1]} + {{W{1'b0}}, stim[0]};
    assign done     = (state == DONE);

    // The sample on a closing edge still belongs to the old window, so settle uses the
    // pre-edge last_bad: when the final sample matches, last_bad is already complete.
    always_comb begin
        sample_idx  = cnt + 1'b1;
        sample_bad  = ({dut_c, dut_s} != expected);
        settle      = last_bad + 1'b1;
        close_win   = 1'b0;
        clear_stats = 1'b0;
        next_state  = state;
        case (state)
            IDLE, HOLD: begin
                if (stim_valid)     next_state = MEASURE;
                else if (sweep_end) next_state = DONE;
            end
            MEASURE: begin
                close_win = stim_valid || sweep_end || (sample_idx == TIMEOUT_C);
                if (stim_valid)                    next_state = MEASURE;
                else if (sweep_end)                next_state = DONE;
                else if (sample_idx == TIMEOUT_C)  next_state = HOLD;
            end
            DONE: begin
                if (stim_valid) begin
                    next_state  = MEASURE;
                    clear_stats = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            settle_cnt   <= '0;
            result_err   <= 1'b0;
            max_settle   <= '0;
            max_from     <= '0;
            max_to       <= '0;
            err_cnt      <= '0;
            err_flag     <= 1'b0;
            cur          <= '0;
            prev         <= '0;
            expected     <= '0;
            cnt          <= '0;
            last_bad     <= '0;
        end else begin
            result_valid <= close_win;
            settle_cnt   <= '0;
            result_err   <= 1'b0;
            if (close_win) begin
                if (sample_bad) begin
                    result_err <= 1'b1;
                    err_flag   <= 1'b1;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end else begin
                    settle_cnt <= settle;
                    // Strictly greater keeps the earliest of equally slow transitions.
                    if (settle > max_settle) begin
                        max_settle <= settle;
                        max_from   <= prev;
                        max_to     <= cur;
                    end
                end
            end
            if (clear_stats) begin
                max_settle <= '0;
                max_from   <= '0;
                max_to     <= '0;
                err_cnt    <= '0;
                err_flag   <= 1'b0;
            end
            if (stim_valid) begin
                prev     <= cur;
                cur      <= stim;
                expected <= stim_sum;
                cnt      <= '0;
                last_bad <= '0;
            end else if (state == MEASURE) begin
                cnt <= sample_idx;
                if (sample_bad) last_bad <= sample_idx;
            end
        end
    end

endmodule

// File: tb/tb_cla_response_checker.sv
// Bench for cla_response_checker: plays the adder under test with scripted per-sample
// mismatch masks and scores every result pulse against a window-level reference model.
module tb_cla_response_checker;

    localparam int W       = 3;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic        clk;
    logic        rst_n;
    logic        stim_valid;
    logic [6:0]  stim;
    logic        sweep_end;
    logic        dut_c;
    logic [2:0]  dut_s;
    logic        result_valid;
    logic [3:0]  settle_cnt;
    logic        result_err;
    logic [3:0]  max_settle;
    logic [6:0]  max_from;
    logic [6:0]  max_to;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic        done;

    cla_response_checker #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stim_valid(stim_valid), .stim(stim),
        .sweep_end(sweep_end), .dut_c(dut_c), .dut_s(dut_s),
        .result_valid(result_valid), .settle_cnt(settle_cnt), .result_err(result_err),
        .max_settle(max_settle), .max_from(max_from), .max_to(max_to),
        .err_cnt(err_cnt), .err_flag(err_flag), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         err;
        int         settle;
        int         max_s;
        logic [6:0] from_s;
        logic [6:0] to_s;
        int         errcnt;
        bit         errflag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [6:0]  m_cur, m_prev, m_from, m_to;
    int          m_max, m_errcnt;
    bit          m_errflag, m_done, pend;
    int          win_n;
    logic [15:0] win_mask;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] golden(input logic [6:0] s);
        return 4'(s[6:4]) + 4'(s[3:1]) + 4'(s[0]);
    endfunction

    function automatic logic [3:0] respond(input logic [3:0] good, input bit bad);
        if (bad) return good ^ 4'($urandom_range(1, 15));
        return good;
    endfunction

    task automatic tick(input logic sv, input logic [6:0] st, input logic se, input logic [3:0] resp);
        @(negedge clk);
        stim_valid     = sv;
        stim           = st;
        sweep_end      = se;
        {dut_c, dut_s} = resp;
        @(posedge clk);
    endtask

    // Window outcome straight from the mask: settle follows the last bad sample, and a
    // bad final sample fails the window.
    task automatic close_window();
        int   lb;
        bit   fail;
        int   settle;
        exp_t e;
        lb = 0;
        for (int j = 1; j <= win_n; j++) if (win_mask[j]) lb = j;
        fail   = win_mask[win_n];
        settle = fail ? 0 : lb + 1;
        if (fail) begin
            if (m_errcnt < 65535) m_errcnt++;
            m_errflag = 1'b1;
        end else if (settle > m_max) begin
            m_max  = settle;
            m_from = m_prev;
            m_to   = m_cur;
        end
        e = '{fail, settle, m_max, m_from, m_to, m_errcnt, m_errflag};
        exp_q.push_back(e);
    endtask

    // mode 0: left open for the next stim/sweep edge; 1: runs to timeout; 2: sweep_end on the last sample
    task automatic applyStimulus(input logic [6:0] s, input int n, input logic [15:0] mask,
                                 input int mode, input bit se);
        logic [3:0] r;
        bit         was_done;
        r = pend ? respond(golden(m_cur), win_mask[win_n]) : 4'($urandom_range(0, 15));
        if (pend) close_window();
        was_done = m_done;
        if (m_done) begin
            m_max = 0; m_from = '0; m_to = '0; m_errcnt = 0; m_errflag = 1'b0; m_done = 1'b0;
        end
        m_prev   = m_cur;
        m_cur    = s;
        win_n    = n;
        win_mask = mask;
        pend     = 1'b0;
        tick(1'b1, s, se, r);
        if (was_done) begin
            #1;
            checkOutput("done_clear", done, 0);
            checkOutput("max_clear", max_settle, 0);
            checkOutput("errcnt_clear", err_cnt, 0);
            checkOutput("errflag_clear", err_flag, 0);
        end
        for (int j = 1; j < n; j++) tick(1'b0, 7'($urandom), 1'b0, respond(golden(s), mask[j]));
        case (mode)
            0: pend = 1'b1;
            1: begin
                close_window();
                tick(1'b0, 7'($urandom), 1'b0, respond(golden(s), mask[n]));
                repeat (2) tick(1'b0, 7'($urandom), 1'b0, 4'($urandom));
            end
            default: begin
                close_window();
                tick(1'b0, 7'($urandom), 1'b1, respond(golden(s), mask[n]));
                m_done = 1'b1;
                #1 checkOutput("done_set", done, 1);
            end
        endcase
    endtask

    task automatic endSweep();
        logic [3:0] r;
        r = pend ? respond(golden(m_cur), win_mask[win_n]) : 4'($urandom_range(0, 15));
        if (pend) close_window();
        pend = 1'b0;
        tick(1'b0, 7'($urandom), 1'b1, r);
        m_done = 1'b1;
        #1 checkOutput("done_set", done, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_settle_cnt"}, settle_cnt, 0);
        checkOutput({tag, "_result_err"}, result_err, 0);
        checkOutput({tag, "_max_settle"}, max_settle, 0);
        checkOutput({tag, "_max_from"}, max_from, 0);
        checkOutput({tag, "_max_to"}, max_to, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_err_flag"}, err_flag, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    task automatic resetModel();
        m_cur = '0; m_prev = '0; m_from = '0; m_to = '0;
        m_max = 0; m_errcnt = 0; m_errflag = 1'b0; m_done = 1'b0; pend = 1'b0;
        win_n = 1; win_mask = '0;
    endtask

    // Monitor: every result pulse is matched against the oldest expected window.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_result: result_valid=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("result_err", result_err, mon_e.err);
                checkOutput("settle_cnt", settle_cnt, mon_e.settle);
                checkOutput("max_settle", max_settle, mon_e.max_s);
                checkOutput("max_from", max_from, mon_e.from_s);
                checkOutput("max_to", max_to, mon_e.to_s);
                checkOutput("err_cnt", err_cnt, mon_e.errcnt);
                checkOutput("err_flag", err_flag, mon_e.errflag);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n, mode, cut, r;
        logic [15:0] mask;
        stim_valid = 1'b0; stim = '0; sweep_end = 1'b0; dut_c = 1'b0; dut_s = '0;
        rst_n = 1'b1;
        resetModel();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        applyStimulus(7'h7F, 3, 16'h0000, 0, 1'b0);
        applyStimulus(7'h00, 8, 16'h001E, 0, 1'b0);
        applyStimulus(7'h7F, 8, 16'h001E, 0, 1'b0);
        applyStimulus(7'h2A, 8, 16'h0012, 0, 1'b0);
        applyStimulus(7'h03, TIMEOUT, 16'hFFFE, 1, 1'b0);
        applyStimulus(7'h11, 3, 16'h0002, 2, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(7'(8'h44 + i), 1, 16'h0000, 0, 1'b0);
        applyStimulus(7'h5A, 2, 16'h0000, 0, 1'b1);

        applyStimulus(7'h55, 3, 16'h0000, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState("async_reset");
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(7'h26, 2, 16'h0000, 0, 1'b0);
        applyStimulus(7'h40, 2, 16'h0002, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                endSweep();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 7)      begin mode = 0; n = $urandom_range(1, TIMEOUT - 1); end
                else if (r < 9) begin mode = 1; n = TIMEOUT; end
                else            begin mode = 2; n = $urandom_range(1, TIMEOUT - 1); end
                cut  = $urandom_range(1, n + 1);
                mask = '0;
                for (int j = 1; j <= n; j++) if (j < cut && $urandom_range(0, 1) == 1) mask[j] = 1'b1;
                if ($urandom_range(0, 7) == 0) mask[n] = 1'b1;
                applyStimulus(7'($urandom), n, mask, mode, ($urandom_range(0, 7) == 0));
            end
        end

        endSweep();
        repeat (3) tick(1'b0, 7'h00, 1'b0, 4'h0);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
